// File: rtl/mac_pkg.sv
// Shared width helpers and saturation bounds for the streaming MAC.
package mac_pkg;

  function automatic int prod_w(input int dw, input int ww);
    return dw + ww;
  endfunction

  function automatic int bsum_w(input int dw, input int ww, input int lanes);
    return prod_w(dw, ww) + $clog2(lanes);
  endfunction

  function automatic int acc_iw(input int dw, input int ww,
                                input int lanes, input int depth);
    return bsum_w(dw, ww, lanes) + $clog2(depth);
  endfunction

  function automatic longint sat_hi(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_lo(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/mac_lane_mult.sv
// One lane: unsigned activation times signed weight, exact product.
module mac_lane_mult
  import mac_pkg::*;
#(
  parameter int DW = 8,
  parameter int WW = 8
) (
  input  logic [DW-1:0]                      a,
  input  logic signed [WW-1:0]               w,
  output logic signed [prod_w(DW, WW)-1:0]   p
);

  localparam int P = prod_w(DW, WW);

  assign p = P'($signed({1'b0, a})) * P'(w);

endmodule

// File: rtl/mac_stream_acc.sv
// Streaming multiply-accumulate with valid/ready on both sides.
// Optional output clamping when MAC_SAT_EN is defined.
module mac_stream_acc
  import mac_pkg::*;
#(
  parameter int LANES = 3,
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int DEPTH = 3,
  parameter int ACC_W = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   data,
  input  logic [LANES*WW-1:0]   weight,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      result,
  output logic                  sat
);

  localparam int P  = prod_w(DW, WW);
  localparam int SW = bsum_w(DW, WW, LANES);
  localparam int IW = acc_iw(DW, WW, LANES, DEPTH);
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  logic signed [P-1:0]  prod [LANES];
  logic signed [SW-1:0] bsum;
  logic signed [IW-1:0] acc, base, sum;
  logic [CW-1:0]        cnt, cnt_b;
  logic                 fire, last;
  logic [ACC_W-1:0]     conv;
  logic                 conv_sat;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane_mult #(
      .DW(DW),
      .WW(WW)
    ) u_mult (
      .a(data[i*DW +: DW]),
      .w(weight[i*WW +: WW]),
      .p(prod[i])
    );
  end

  always_comb begin
    bsum = '0;
    for (int i = 0; i < LANES; i++)
      bsum = bsum + SW'(prod[i]);
  end

  assign in_ready = !out_valid || out_ready;
  assign fire     = in_valid && in_ready;

  // clr with a beat makes that beat the first of a fresh group
  assign base  = clr ? '0 : acc;
  assign cnt_b = clr ? '0 : cnt;
  assign last  = (cnt_b == LAST);
  assign sum   = base + IW'(bsum);

  if (IW <= ACC_W) begin : g_ext
    assign conv     = ACC_W'(sum);
    assign conv_sat = 1'b0;
  end else begin : g_narrow
`ifdef MAC_SAT_EN
    localparam logic signed [IW-1:0] HI = IW'(sat_hi(ACC_W));
    localparam logic signed [IW-1:0] LO = IW'(sat_lo(ACC_W));
    always_comb begin
      conv     = ACC_W'(sum);
      conv_sat = 1'b0;
      if (sum > HI) begin
        conv     = ACC_W'(HI);
        conv_sat = 1'b1;
      end else if (sum < LO) begin
        conv     = ACC_W'(LO);
        conv_sat = 1'b1;
      end
    end
`else
    assign conv     = ACC_W'(sum);
    assign conv_sat = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (fire) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt_b + CW'(1);
      end
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      sat       <= 1'b0;
    end else if (fire && last) begin
      out_valid <= 1'b1;
      result    <= conv;
      sat       <= conv_sat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_stream_acc.sv
// Directed bench for mac_stream_acc (ACC_W=20 and ACC_W=16 instances).
// Group sums come from a plain arithmetic model of the beat stream.
module tb_mac_stream_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [23:0] data = '0;
  logic [23:0] weight = '0;

  logic        ir, ov, st;
  logic [19:0] res;
  logic        ir16, ov16, st16;
  logic [15:0] res16;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mac_stream_acc dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(ir),
    .data(data), .weight(weight),
    .out_valid(ov), .out_ready(out_ready),
    .result(res), .sat(st)
  );

  mac_stream_acc #(.ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(ir16),
    .data(data), .weight(weight),
    .out_valid(ov16), .out_ready(out_ready),
    .result(res16), .sat(st16)
  );

  task automatic chk(input string nm, input longint a, input longint e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, a, e, $time);
    end
  endtask

  // model: whole-number group sums
  bit     m_ov;
  longint m_res, m_acc, bs;
  int     m_cnt;
  bit     m_fire;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ov = 0; m_res = 0; m_acc = 0; m_cnt = 0;
    end else begin
      bs = 0;
      for (int i = 0; i < 3; i++)
        bs += longint'(data[i*8 +: 8]) * longint'($signed(weight[i*8 +: 8]));
      m_fire = in_valid && (!m_ov || out_ready);
      if (clr) begin m_acc = 0; m_cnt = 0; end
      if (m_ov && out_ready) m_ov = 0;
      if (m_fire) begin
        m_acc += bs;
        m_cnt++;
        if (m_cnt == 3) begin
          m_res = m_acc; m_ov = 1; m_acc = 0; m_cnt = 0;
        end
      end
    end
  end

  function automatic logic [15:0] e16(input longint v);
`ifdef MAC_SAT_EN
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  function automatic bit s16(input longint v);
`ifdef MAC_SAT_EN
    return (v > 32767) || (v < -32768);
`else
    return 1'b0 && (v != 0);
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("ov", ov, m_ov);
      chk("ir", ir, !m_ov || out_ready);
      chk("res", res, m_res[19:0]);
      chk("sat", st, 0);
      chk("ov16", ov16, m_ov);
      chk("res16", res16, e16(m_res));
      chk("sat16", st16, s16(m_res));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [23:0] d, input logic [23:0] w,
                      input logic c);
    data = d; weight = w; clr = c; in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (ir) begin
        step();
        in_valid = 1'b0; clr = 1'b0;
        return;
      end
      step();
    end
    chk("beat_timeout", 1, 0);
    in_valid = 1'b0; clr = 1'b0;
  endtask

  localparam logic [23:0] FF = 24'hFFFFFF;
  localparam logic [23:0] W7F = 24'h7F7F7F;
  localparam logic [23:0] ONE = 24'h010101;
  localparam logic [23:0] TWO = 24'h020202;

  initial begin
    #12;
    chk("rst_ov", ov, 0);
    chk("rst_res", res, 0);
    chk("rst_sat", st, 0);
    chk("rst_ir", ir, 1);
    rst = 1'b0;
    step();

    // max activations, most negative weights
    for (int b = 0; b < 3; b++) beat(FF, 24'h808080, 0);
    chk("t1_ov", ov, 1);
    chk("t1_res", res, 20'hB8480);
    chk("t1_sat", st, 0);

    // two groups with no gap
    for (int b = 0; b < 6; b++) begin
      chk("t2_ir", ir, 1);
      beat(FF, W7F, 0);
      if (b == 2) begin
        chk("t2_res_a", res, 20'h47289);
`ifdef MAC_SAT_EN
        chk("t2_res16", res16, 16'h7fff);
        chk("t2_sat16", st16, 1);
`else
        chk("t2_res16", res16, 16'h7289);
        chk("t2_sat16", st16, 0);
`endif
      end
      if (b == 3) chk("t2_ov_drop", ov, 0);
    end
    chk("t2_ov_b", ov, 1);
    chk("t2_res_b", res, 20'h47289);
    step();

    // backpressure
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) beat(FF, W7F, 0);
    data = ONE; weight = ONE; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t3_stall_ir", ir, 0);
      chk("t3_hold", res, 20'h47289);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) beat(ONE, ONE, 0);
    chk("t3_res", res, 9);
    step();

    // clr alone, then clr with a beat
    beat(ONE, ONE, 0);
    beat(ONE, ONE, 0);
    clr = 1'b1; step(); clr = 1'b0;
    for (int b = 0; b < 3; b++) beat(TWO, ONE, 0);
    chk("t4_res_a", res, 18);
    beat(ONE, ONE, 0);
    chk("t4_ov_mid", ov, 0);
    beat(TWO, ONE, 1);
    beat(TWO, ONE, 0);
    beat(TWO, ONE, 0);
    chk("t4_res_b", res, 18);

    // distinct lanes: 1*7 + 2*5 + 3*(-1)
    for (int b = 0; b < 3; b++) beat(24'h030201, 24'hFF0507, 0);
    chk("t5_res", res, 42);

    // async reset mid-group
    beat(ONE, ONE, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_ov", ov, 0);
    chk("t6_res", res, 0);
    rst = 1'b0;
    step();
    for (int b = 0; b < 3; b++) beat(FF, W7F, 0);
    chk("t6_res_a", res, 20'h47289);

    // async reset with result held
    out_ready = 1'b0;
    step();
    chk("t6_held", ov, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_ov2", ov, 0);
    chk("t6_res2", res, 0);
    chk("t6_sat16", st16, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    for (int b = 0; b < 3; b++) beat(TWO, 24'h030303, 0);
    chk("t6_fresh", res, 54);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
